instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter D, default 12, is the instruction-memory address width; the memory depth is 2**D words of 9 bits.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  is the asynchronous, active-low reset.
REQ-004 load_req  input  1  is a one-cycle request to start a new program load at address 0.
REQ-005 in_valid  input  1  indicates that in_data/in_last carry a valid machine-code word.
REQ-006 in_data  input  9  is the machine-code word offered by the host.
REQ-007 in_last  input  1  marks the final word of the program and is qualified by in_valid.
REQ-008 in_ready  output  1  indicates the loader accepts a word this cycle.
REQ-009 wr_en  output  1  is the instruction-memory write strobe.
REQ-010 wr_addr  output  D  is the instruction-memory write address.
REQ-011 wr_data  output  9  is the instruction-memory write data.
REQ-012 busy  output  1  is high while in LOAD.
REQ-013 done  output  1  is high while in DONE.
REQ-014 core_start  output  1  is a one-cycle pulse that releases the core after a successful load.
REQ-015 err  output  1  is high while in ERR.
REQ-016 word_count  output  D+1  holds the number of words accepted in the current or last load.
REQ-017 checksum  output  9  holds the sum modulo 512 of all words accepted in the current or last load.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, DONE and ERR.
REQ-019 load_req in IDLE, DONE or ERR SHALL go to LOAD next cycle and clear word_count, checksum and the write pointer to 0.
REQ-020 load_req while in LOAD SHALL be ignored.
REQ-021 in_ready SHALL equal (state==LOAD), combinationally from the state register.
REQ-022 A word is accepted only in a cycle where in_valid and in_ready are both high; in_valid without in_ready SHALL have no effect.
REQ-023 A word accepted in cycle N SHALL produce wr_en=1 in cycle N+1, with wr_addr equal to the pointer value at N and wr_data equal to in_data at N.
REQ-024 wr_en SHALL be 0 in every cycle not following an acceptance.
REQ-025 Each acceptance SHALL increment word_count and the pointer by 1 and add in_data to checksum modulo 512, all updated at the same edge as the write registers.
REQ-026 An acceptance with in_last=1 SHALL move the FSM to DONE.
REQ-027 core_start SHALL be 1 only in the first cycle of DONE, coincident with the final wr_en.
REQ-028 An acceptance with in_last=0 at pointer 2**D-1 SHALL write that word and move the FSM to ERR; core_start SHALL stay 0 in that case.
REQ-029 An acceptance with in_last=1 at pointer 2**D-1 SHALL go to DONE; a load of exactly 2**D words is legal and word_count reads 2**D.
REQ-030 The pointer SHALL never wrap within a load.
REQ-031 DONE and ERR SHALL hold until load_req; word_count and checksum SHALL remain stable while in those states.
REQ-032 If load_req coincides with the cycle after an acceptance, the pending write SHALL still issue and the counters SHALL clear at the next edge.

Reset
REQ-033 On reset_n=0 the FSM SHALL immediately enter IDLE.
REQ-034 On reset_n=0 the following outputs SHALL be 0: wr_en, wr_addr, wr_data, word_count, checksum, busy, done, err, core_start and in_ready.
REQ-035 A reset asserted mid-load SHALL abort the load with no further writes, and SHALL NOT produce core_start.

Verification
REQ-036 Basic load: load_req, then words 0x1FE, 0x0CC, 0x0F4 (last) back-to-back -> writes addr 0,1,2 with those words, core_start at the third write, word_count=3, checksum=0x1BE.
REQ-037 Gapped input: in_valid toggling 1,0,1,0 with 2 words (second last) -> exactly 2 wr_en pulses, no write in gap cycles, done=1.
REQ-038 Overflow (D=4): 16 words with in_last never set -> 16 writes to addr 0..15, err=1, core_start never set; a 16-word load with in_last on word 16 -> done=1, word_count=16.
REQ-039 Reload: after DONE, load_req then a 1-word load of 0x155 (last) -> write at addr 0, word_count=1, checksum=0x155.
REQ-040 Reset mid-load: reset_n low after 2 accepted words -> all outputs 0 asynchronously, no core_start, IDLE after release.
REQ-041 Ignored requests: load_req during LOAD -> counters not cleared; in_valid while IDLE -> in_ready=0, no writes.

Source files
------------

// File: rtl/instr_loader_if.sv
// Host word stream plus instruction-memory write port.
// Ports: in_valid/in_data/in_last/in_ready, wr_en/wr_addr/wr_data.
interface instr_loader_if #(
   parameter int D = 12
);
   logic         in_valid;
   logic [8:0]   in_data;
   logic         in_last;
   logic         in_ready;
   logic         wr_en;
   logic [D-1:0] wr_addr;
   logic [8:0]   wr_data;

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/instr_loader.sv
// Loads a program into instruction memory and releases the core.
// Ports: clk, reset_n, load_req, bus (slave), status and counters.
module instr_loader #(
   parameter int D = 12
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_req,
   instr_loader_if.slave bus,
   output logic         busy,
   output logic         done,
   output logic         core_start,
   output logic         err,
   output logic [D:0]   word_count,
   output logic [8:0]   checksum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [D:0] LAST_PTR = {1'b0, {D{1'b1}}};

   state_t       state_q, state_d;
   logic [D:0]   cnt_q, cnt_d;
   logic [8:0]   sum_q, sum_d;
   logic         wr_en_q, wr_en_d;
   logic [D-1:0] wr_addr_q, wr_addr_d;
   logic [8:0]   wr_data_q, wr_data_d;

   logic accept;
   logic at_end;
   logic restart;

   // cnt_q doubles as the write pointer; it stops at 2**D
   // because the FSM leaves LOAD on the last legal slot.
   assign accept  = bus.in_valid & (state_q == S_LOAD);
   assign at_end  = (cnt_q == LAST_PTR);
   assign restart = load_req & (state_q != S_LOAD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_LOAD: begin
            if (accept) begin
               if (bus.in_last) begin
                  state_d = S_DONE;
               end else if (at_end) begin
                  state_d = S_ERR;
               end
            end
         end
         default: begin
            if (load_req) begin
               state_d = S_LOAD;
            end
         end
      endcase
   end

   always_comb begin
      busy       = (state_q == S_LOAD);
      done       = (state_q == S_DONE);
      err        = (state_q == S_ERR);
      bus.in_ready = (state_q == S_LOAD);
      // The final write lands in the first DONE cycle only.
      core_start = (state_q == S_DONE) & wr_en_q;
   end

   always_comb begin
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      wr_en_d   = accept;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (accept) begin
         cnt_d     = cnt_q + 1'b1;
         sum_d     = sum_q + bus.in_data;
         wr_addr_d = cnt_q[D-1:0];
         wr_data_d = bus.in_data;
      end else if (restart) begin
         cnt_d = '0;
         sum_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         sum_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign word_count  = cnt_q;
   assign checksum    = sum_q;

endmodule
